video_mode_select: RTL and testbench
====================================

VIDEO_MODE_SELECT -- requirements
Module: video_mode_select

Parameters
REQ-001 The block SHALL have parameter NUM_MODES, default 3, meaning the number of selectable video modes (2..16).
REQ-002 The block SHALL have parameter CODE_WIDTH, default 8, meaning the width of the incoming mode command code.
REQ-003 The block SHALL have parameter MODE_CODES, default {8'h03,8'h02,8'h01}, meaning the packed code table in which entry i occupies bits [i*CODE_WIDTH +: CODE_WIDTH].
REQ-004 The block SHALL have parameter STABLE_CYCLES, default 4, meaning the number of consecutive matching samples required before a code is accepted (1..65535).
REQ-005 The block SHALL have parameter DEFAULT_INDEX, default 0, meaning the mode index loaded at reset.

Interface (IW = $clog2(NUM_MODES))
REQ-006 The block SHALL have port clock, input, width 1: the single clock; all logic is rising-edge.
REQ-007 The block SHALL have port reset, input, width 1: reset, asynchronous and active-high.
REQ-008 The block SHALL have port data_in, input, width CODE_WIDTH: the mode command code, which may be asynchronous or bouncy.
REQ-009 The block SHALL have port change_ack, input, width 1: the downstream acknowledgement (pixel PLL or timing reconfiguration done).
REQ-010 The block SHALL have port mode_index, output, width IW: the currently applied mode.
REQ-011 The block SHALL have port pending_index, output, width IW: the requested mode, valid while change_req is high.
REQ-012 The block SHALL have port change_req, output, width 1: the request to switch to pending_index.
REQ-013 The block SHALL have port mode_changed, output, width 1: a one-cycle pulse when mode_index updates.
REQ-014 The block SHALL have port unknown_code, output, width 1: a one-cycle pulse when a stable code matches no table entry.

Function
REQ-015 Sample register s SHALL load data_in every cycle.
REQ-016 Stability counter cnt SHALL clear on any edge where data_in != s; otherwise it SHALL increment, saturating at STABLE_CYCLES.
REQ-017 Armed flag SHALL be set on any edge where data_in != s and cleared when an evaluation occurs.
REQ-018 An evaluation SHALL occur on an edge in state IDLE where the armed flag is set and cnt (pre-edge) equals STABLE_CYCLES-1 or greater with data_in == s, i.e. cnt reaches saturation.
- Result: at most one evaluation per stable episode.
REQ-019 Code lookup SHALL be combinational over the table; on duplicate codes the lowest index wins.
REQ-020 The FSM SHALL have two states, IDLE and REQUEST.
REQ-021 On evaluation in IDLE, an unknown code SHALL pulse unknown_code for 1 cycle with state unchanged.
REQ-022 On evaluation in IDLE, a matched index equal to mode_index SHALL cause no action.
REQ-023 On evaluation in IDLE, a matched index different from mode_index SHALL load pending_index, set change_req=1, and move to REQUEST.
REQ-024 Latency: change_req SHALL go high after the (STABLE_CYCLES+1)th consecutive rising edge that samples the new value.
REQ-025 In REQUEST, change_req and pending_index SHALL be held constant; evaluations are suppressed, while s, cnt and armed continue to update.
REQ-026 In REQUEST, on an edge with change_ack=1, mode_index SHALL take pending_index, change_req SHALL drop, mode_changed SHALL pulse for 1 cycle, and the state SHALL return to IDLE.
REQ-027 If data_in changed during REQUEST, the armed flag remains set, so the new code SHALL be evaluated on the first IDLE edge meeting REQ-018, with no extra wait when cnt is already saturated.
REQ-028 change_ack in IDLE SHALL be ignored.
REQ-029 Data change and change_ack on the same edge SHALL complete the ack, and the new data starts a fresh count.
REQ-030 change_req SHALL never be withdrawn without change_ack except by reset.

Reset
REQ-031 While reset is high, the following SHALL hold asynchronously: state=IDLE, mode_index=DEFAULT_INDEX, pending_index=DEFAULT_INDEX, change_req=0, mode_changed=0, unknown_code=0, cnt=0, armed=1, s=0.
REQ-032 Reset mid-REQUEST SHALL abandon the request with no mode_changed pulse.
REQ-033 After reset release, a code held stable SHALL be evaluated per REQ-018, so a stable power-up code is applied without needing a transition.

Verification (defaults: codes 01/02/03, STABLE_CYCLES=4, DEFAULT_INDEX=0)
REQ-034 Scenario "basic switch": release reset with data_in=8'h02 held and change_ack tied to change_req delayed 3 cycles -> change_req rises on the 5th edge after release with pending_index=1, then mode_index=1 and a single mode_changed pulse.
REQ-035 Scenario "glitch reject": from mode 0, toggle data_in 01->02->01 with the 02 lasting 3 cycles -> no change_req and no unknown_code.
REQ-036 Scenario "same mode": hold 8'h01 while mode_index=0 -> no change_req and no pulses.
REQ-037 Scenario "unknown code": hold 8'h7F for 10 cycles -> exactly one unknown_code pulse, with mode_index unchanged.
REQ-038 Scenario "change during request": request to index 1 pending, data_in switches to 8'h03 and is held; ack after 20 cycles -> mode_index=1, then change_req reasserts on the next edge with pending_index=2.
REQ-039 Scenario "reset mid-request": assert reset while change_req=1 -> change_req=0 and mode_index=0 immediately (asynchronously), with no mode_changed pulse.

Source files
------------

// File: rtl/video_mode_select.sv
// video_mode_select
// Debounces an incoming video mode command code, maps it through a code
// table to a mode index and runs a request/acknowledge handshake with the
// downstream reconfiguration logic (pixel PLL, timing generator).
//
// Ports:
//   clock          rising-edge clock
//   reset          asynchronous, active-high reset
//   data_in        mode command code (may be asynchronous / bouncy)
//   change_ack     downstream acknowledge of a requested mode switch
//   mode_index     currently applied mode
//   pending_index  requested mode, valid while change_req is high
//   change_req     request to switch to pending_index
//   mode_changed   one-cycle pulse when mode_index updates
//   unknown_code   one-cycle pulse when a stable code matches no table entry
module video_mode_select #(
    parameter int NUM_MODES     = 3,
    parameter int CODE_WIDTH    = 8,
    parameter logic [NUM_MODES*CODE_WIDTH-1:0] MODE_CODES = {8'h03, 8'h02, 8'h01},
    parameter int STABLE_CYCLES = 4,
    parameter int DEFAULT_INDEX = 0,
    localparam int IW = $clog2(NUM_MODES),
    localparam int CW = $clog2(STABLE_CYCLES + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [CODE_WIDTH-1:0] data_in,
    input  logic                  change_ack,
    output logic [IW-1:0]         mode_index,
    output logic [IW-1:0]         pending_index,
    output logic                  change_req,
    output logic                  mode_changed,
    output logic                  unknown_code
);

    typedef enum logic {IDLE = 1'b0, REQUEST = 1'b1} state_t;

    localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_EVAL = CW'(STABLE_CYCLES - 1);
    localparam logic [IW-1:0] DEF_IDX  = IW'(DEFAULT_INDEX);

    state_t                  state, state_nxt;
    logic [CODE_WIDTH-1:0]   s;
    logic [CW-1:0]           cnt;
    logic                    armed;
    logic                    diff;
    logic                    eval;
    logic                    hit;
    logic [IW-1:0]           hit_idx;

    logic [IW-1:0]           mode_nxt, pend_nxt;
    logic                    req_nxt, chg_nxt, unk_nxt;

    assign diff = (data_in != s);
    // One evaluation per stable episode: armed is consumed by the evaluation
    // and only re-armed by a new transition. Suppressed while a request is open.
    assign eval = (state == IDLE) && armed && !diff && (cnt >= CNT_EVAL);

    // Table lookup on the settled sample; scanning downward lets the lowest
    // matching index win on duplicate codes.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_MODES - 1; i >= 0; i--) begin
            if (s == MODE_CODES[i*CODE_WIDTH +: CODE_WIDTH]) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
            end
        end
    end

    // Debounce datapath
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s     <= '0;
            cnt   <= '0;
            armed <= 1'b1;   // lets a code held through reset be applied
        end else begin
            s <= data_in;
            if (diff)
                cnt <= '0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + 1'b1;
            if (diff)
                armed <= 1'b1;
            else if (eval)
                armed <= 1'b0;
        end
    end

    // FSM state and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            mode_index    <= DEF_IDX;
            pending_index <= DEF_IDX;
            change_req    <= 1'b0;
            mode_changed  <= 1'b0;
            unknown_code  <= 1'b0;
        end else begin
            state         <= state_nxt;
            mode_index    <= mode_nxt;
            pending_index <= pend_nxt;
            change_req    <= req_nxt;
            mode_changed  <= chg_nxt;
            unknown_code  <= unk_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mode_nxt  = mode_index;
        pend_nxt  = pending_index;
        req_nxt   = change_req;
        chg_nxt   = 1'b0;
        unk_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (eval) begin
                    if (!hit) begin
                        unk_nxt = 1'b1;
                    end else if (hit_idx != mode_index) begin
                        pend_nxt  = hit_idx;
                        req_nxt   = 1'b1;
                        state_nxt = REQUEST;
                    end
                end
            end
            REQUEST: begin
                if (change_ack) begin
                    mode_nxt  = pending_index;
                    req_nxt   = 1'b0;
                    chg_nxt   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_video_mode_select.sv
module tb_video_mode_select;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       change_ack = 1'b0;
    logic [1:0] mode_index, pending_index;
    logic       change_req, mode_changed, unknown_code;

    int n_cmp = 0;
    int n_bad = 0;

    video_mode_select dut (
        .clock        (clock),
        .reset        (reset),
        .data_in      (data_in),
        .change_ack   (change_ack),
        .mode_index   (mode_index),
        .pending_index(pending_index),
        .change_req   (change_req),
        .mode_changed (mode_changed),
        .unknown_code (unknown_code)
    );

    always #5 clock = ~clock;

    // Each call returns at the negedge following the next rising edge.
    task automatic tick();
        @(negedge clock);
    endtask

    task automatic do_reset(input logic [7:0] code);
        reset = 1'b1; data_in = code; change_ack = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; data_in = 8'h02; change_ack = 1'b0;
        tick(); tick();
        n_cmp++; if (mode_index !== 2'd0) begin n_bad++; $display("FAIL reset_mode got=%0d exp=0", mode_index); end
        n_cmp++; if (pending_index !== 2'd0) begin n_bad++; $display("FAIL reset_pend got=%0d exp=0", pending_index); end
        n_cmp++; if (change_req !== 1'b0) begin n_bad++; $display("FAIL reset_req got=%b exp=0", change_req); end
        n_cmp++; if (mode_changed !== 1'b0 || unknown_code !== 1'b0) begin n_bad++; $display("FAIL reset_pulses got=%b%b exp=00", mode_changed, unknown_code); end
    endtask

    // Release with 02 held: request after the 5th edge, ack 3 cycles later.
    task automatic test_basic_switch();
        int pulses = 0;
        reset = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            tick();
            n_cmp++; if (change_req !== (e == 5)) begin n_bad++; $display("FAIL basic_req_edge%0d got=%b exp=%b", e, change_req, (e == 5)); end
        end
        n_cmp++; if (pending_index !== 2'd1) begin n_bad++; $display("FAIL basic_pend got=%0d exp=1", pending_index); end
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++; if (change_req !== 1'b1 || mode_index !== 2'd0) begin n_bad++; $display("FAIL basic_hold req=%b mode=%0d exp req=1 mode=0", change_req, mode_index); end
        end
        change_ack = 1'b1;
        tick();
        change_ack = 1'b0;
        pulses += int'(mode_changed);
        n_cmp++; if (mode_index !== 2'd1) begin n_bad++; $display("FAIL basic_mode got=%0d exp=1", mode_index); end
        n_cmp++; if (change_req !== 1'b0) begin n_bad++; $display("FAIL basic_req_drop got=%b exp=0", change_req); end
        for (int c = 0; c < 6; c++) begin
            tick();
            pulses += int'(mode_changed);
        end
        n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL basic_pulses got=%0d exp=1", pulses); end
    endtask

    task automatic test_same_mode();
        int bad = 0;
        do_reset(8'h01);
        for (int c = 0; c < 12; c++) begin
            change_ack = (c >= 6);   // ack in IDLE must be ignored
            tick();
            if (change_req !== 1'b0 || mode_changed !== 1'b0 || unknown_code !== 1'b0 || mode_index !== 2'd0) bad++;
        end
        change_ack = 1'b0;
        n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL same_mode bad_cycles got=%0d exp=0", bad); end
    endtask

    task automatic test_glitch_reject();
        int bad = 0;
        data_in = 8'h02;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (change_req !== 1'b0 || unknown_code !== 1'b0) bad++;
        end
        data_in = 8'h01;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (change_req !== 1'b0 || unknown_code !== 1'b0) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL glitch bad_cycles got=%0d exp=0", bad); end
        n_cmp++; if (mode_index !== 2'd0) begin n_bad++; $display("FAIL glitch_mode got=%0d exp=0", mode_index); end
    endtask

    task automatic test_unknown_code();
        int pulses = 0;
        data_in = 8'h7F;
        for (int e = 1; e <= 10; e++) begin
            tick();
            pulses += int'(unknown_code);
            n_cmp++; if (unknown_code !== (e == 5)) begin n_bad++; $display("FAIL unknown_edge%0d got=%b exp=%b", e, unknown_code, (e == 5)); end
            if (change_req !== 1'b0) begin n_bad++; n_cmp++; $display("FAIL unknown_req edge%0d got=1 exp=0", e); end
        end
        n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL unknown_count got=%0d exp=1", pulses); end
        n_cmp++; if (mode_index !== 2'd0) begin n_bad++; $display("FAIL unknown_mode got=%0d exp=0", mode_index); end
    endtask

    task automatic test_change_during_request();
        int bad = 0;
        data_in = 8'h02;
        for (int e = 1; e <= 5; e++) tick();
        n_cmp++; if (change_req !== 1'b1 || pending_index !== 2'd1) begin n_bad++; $display("FAIL cdr_req req=%b pend=%0d exp req=1 pend=1", change_req, pending_index); end
        data_in = 8'h03;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (change_req !== 1'b1 || pending_index !== 2'd1 || mode_index !== 2'd0) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL cdr_hold bad_cycles got=%0d exp=0", bad); end
        change_ack = 1'b1;
        tick();
        change_ack = 1'b0;
        n_cmp++; if (mode_index !== 2'd1 || mode_changed !== 1'b1 || change_req !== 1'b0) begin n_bad++; $display("FAIL cdr_ack mode=%0d chg=%b req=%b exp mode=1 chg=1 req=0", mode_index, mode_changed, change_req); end
        tick();
        n_cmp++; if (change_req !== 1'b1 || pending_index !== 2'd2) begin n_bad++; $display("FAIL cdr_rereq req=%b pend=%0d exp req=1 pend=2", change_req, pending_index); end
        change_ack = 1'b1;
        tick();
        change_ack = 1'b0;
        n_cmp++; if (mode_index !== 2'd2) begin n_bad++; $display("FAIL cdr_mode2 got=%0d exp=2", mode_index); end
    endtask

    // Data change on the ack edge: ack completes, new code counts from scratch.
    task automatic test_back_to_back();
        data_in = 8'h02;
        for (int e = 1; e <= 5; e++) tick();
        n_cmp++; if (change_req !== 1'b1 || pending_index !== 2'd1) begin n_bad++; $display("FAIL b2b_req req=%b pend=%0d exp req=1 pend=1", change_req, pending_index); end
        change_ack = 1'b1; data_in = 8'h03;
        tick();
        change_ack = 1'b0;
        n_cmp++; if (mode_index !== 2'd1 || mode_changed !== 1'b1) begin n_bad++; $display("FAIL b2b_ack mode=%0d chg=%b exp mode=1 chg=1", mode_index, mode_changed); end
        for (int e = 1; e <= 4; e++) begin
            tick();
            n_cmp++; if (change_req !== (e == 4)) begin n_bad++; $display("FAIL b2b_fresh_edge%0d got=%b exp=%b", e, change_req, (e == 4)); end
        end
        n_cmp++; if (pending_index !== 2'd2) begin n_bad++; $display("FAIL b2b_pend got=%0d exp=2", pending_index); end
    endtask

    task automatic test_reset_mid_request();
        int pulses = 0;
        n_cmp++; if (change_req !== 1'b1 || mode_index !== 2'd1) begin n_bad++; $display("FAIL rmr_pre req=%b mode=%0d exp req=1 mode=1", change_req, mode_index); end
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (change_req !== 1'b0) begin n_bad++; $display("FAIL rmr_req got=%b exp=0", change_req); end
        n_cmp++; if (mode_index !== 2'd0 || pending_index !== 2'd0) begin n_bad++; $display("FAIL rmr_mode mode=%0d pend=%0d exp 0/0", mode_index, pending_index); end
        change_ack = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            pulses += int'(mode_changed);
        end
        change_ack = 1'b0;
        n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL rmr_pulse got=%0d exp=0", pulses); end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_switch();
        test_same_mode();
        test_glitch_reject();
        test_unknown_code();
        test_change_during_request();
        test_back_to_back();
        test_reset_mid_request();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
